// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM macro between two requesters.
// Accepted accesses become a one-cycle SRAM command; read data is routed back
// to the originating requester one cycle later.
// Optional macro SRAM_ARB_RR_EN: round-robin arbitration with a last-grant
// pointer. When it is undefined, m0 has fixed priority over m1.
module sram_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW/8-1:0] m0_wmask_i,
  input  logic [DW-1:0]   m0_wdata_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW/8-1:0] m1_wmask_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            o_csb0,
  output logic            o_web0,
  output logic [DW/8-1:0] o_wmask0,
  output logic [AW-1:0]   o_waddr0,
  output logic [DW-1:0]   o_din0,
  input  logic [DW-1:0]   i_dout0
);

  localparam int MW = DW / 8;

  logic            acc_s;
  logic            owner_s;
  logic            sel_we_s;
  logic [AW-1:0]   sel_addr_s;
  logic [MW-1:0]   sel_wmask_s;
  logic [DW-1:0]   sel_wdata_s;

  logic            csb_r;
  logic            web_r;
  logic [MW-1:0]   wmask_r;
  logic [AW-1:0]   waddr_r;
  logic [DW-1:0]   din_r;

  // stage 1 = command cycle, stage 2 = data-return cycle
  logic            s1_valid_r, s1_owner_r, s1_read_r;
  logic            s2_valid_r, s2_owner_r, s2_read_r;

`ifdef SRAM_ARB_RR_EN
  logic            lp_r;

  // Grant: single requester wins at once; on contention the one not granted last wins
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (rst_i) begin
      m0_gnt_o = 1'b0;
      m1_gnt_o = 1'b0;
    end else if (m0_req_i && m1_req_i) begin
      m0_gnt_o = lp_r;
      m1_gnt_o = ~lp_r;
    end else begin
      m0_gnt_o = m0_req_i;
      m1_gnt_o = m1_req_i;
    end
  end

  // Last-grant pointer; reset to m1 so m0 gets the first contended grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lp_r <= 1'b1;
    end else if (acc_s) begin
      lp_r <= owner_s;
    end else begin
      lp_r <= lp_r;
    end
  end
`else
  // Grant: fixed priority, m0 always beats m1
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (rst_i) begin
      m0_gnt_o = 1'b0;
      m1_gnt_o = 1'b0;
    end else begin
      m0_gnt_o = m0_req_i;
      m1_gnt_o = m1_req_i & ~m0_req_i;
    end
  end
`endif

  // Select the accepted requester's command fields
  always_comb begin
    acc_s   = m0_gnt_o | m1_gnt_o;
    owner_s = m1_gnt_o;
    if (m1_gnt_o) begin
      sel_we_s    = m1_we_i;
      sel_addr_s  = m1_addr_i;
      sel_wmask_s = m1_wmask_i;
      sel_wdata_s = m1_wdata_i;
    end else begin
      sel_we_s    = m0_we_i;
      sel_addr_s  = m0_addr_i;
      sel_wmask_s = m0_wmask_i;
      sel_wdata_s = m0_wdata_i;
    end
  end

  // SRAM command register: one command cycle per acceptance, deselect otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csb_r   <= 1'b1;
      web_r   <= 1'b1;
      wmask_r <= '0;
      waddr_r <= '0;
      din_r   <= '0;
    end else if (acc_s) begin
      csb_r   <= 1'b0;
      web_r   <= ~sel_we_s;
      wmask_r <= sel_wmask_s;
      waddr_r <= sel_addr_s;
      din_r   <= sel_wdata_s;
    end else begin
      csb_r   <= 1'b1;
      web_r   <= 1'b1;
      wmask_r <= '0;
      waddr_r <= waddr_r;
      din_r   <= din_r;
    end
  end

  // In-flight tracking pipeline; reset discards outstanding reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_r <= 1'b0;
      s1_owner_r <= 1'b0;
      s1_read_r  <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_owner_r <= 1'b0;
      s2_read_r  <= 1'b0;
    end else begin
      s1_valid_r <= acc_s;
      s1_owner_r <= owner_s;
      s1_read_r  <= acc_s & ~sel_we_s;
      s2_valid_r <= s1_valid_r;
      s2_owner_r <= s1_owner_r;
      s2_read_r  <= s1_read_r;
    end
  end

  // Route returning SRAM data to its owner; rdata is zero when not valid
  always_comb begin
    m0_rvalid_o = s2_valid_r & s2_read_r & ~s2_owner_r;
    m1_rvalid_o = s2_valid_r & s2_read_r & s2_owner_r;
    if (m0_rvalid_o) begin
      m0_rdata_o = i_dout0;
    end else begin
      m0_rdata_o = '0;
    end
    if (m1_rvalid_o) begin
      m1_rdata_o = i_dout0;
    end else begin
      m1_rdata_o = '0;
    end
  end

  assign o_csb0   = csb_r;
  assign o_web0   = web_r;
  assign o_wmask0 = wmask_r;
  assign o_waddr0 = waddr_r;
  assign o_din0   = din_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with an SRAM model and a
// transaction-level reference model (golden memory + queue of due returns).
module tb_sram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [8:0]    m0_addr, m1_addr;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          o_csb0, o_web0;
  logic [3:0]    o_wmask0;
  logic [8:0]    o_waddr0;
  logic [31:0]   o_din0;
  logic [31:0]   sram_dout;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wmask_i(m0_wmask), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wmask_i(m1_wmask), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .o_csb0(o_csb0), .o_web0(o_web0), .o_wmask0(o_wmask0),
    .o_waddr0(o_waddr0), .o_din0(o_din0), .i_dout0(sram_dout)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    else if (i == 511) return 32'hAAAAAAAA;
    else return 32'hC0DE0000 | i;
  endfunction

  // SRAM macro model: command in one cycle, read data the next
  logic [31:0] sram [512];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) sram[i] <= init_val(i);
    end else if (!o_csb0) begin
      if (!o_web0) begin
        for (int b = 0; b < 4; b++)
          if (o_wmask0[b]) sram[o_waddr0][8*b +: 8] <= o_din0[8*b +: 8];
      end else begin
        sram_dout <= sram[o_waddr0];
      end
    end
  end

  // Reference model state
  typedef struct { int due; bit owner; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  logic [31:0] ref_mem [512];
  bit          m_lp;
  logic        e_csb, e_web;
  logic [3:0]  e_wmask;
  logic [8:0]  e_addr;
  logic [31:0] e_din;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_csb;
  logic [31:0] obs_rd0, obs_rd1;
  logic [3:0]  obs_wmask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    rq.delete();
    m_lp = 1'b1;
    e_csb = 1'b1; e_web = 1'b1; e_wmask = 4'h0; e_addr = 9'h0; e_din = 32'h0;
  endtask

  // One clock cycle: check outputs at the negedge, then advance the model at the posedge
  task automatic cycle();
    bit g0, g1, own, we, rv0, rv1;
    logic [31:0] rd0, rd1, wd;
    logic [8:0] a;
    logic [3:0] mk;
    @(negedge clk);
    if (rst) model_reset();
    g0 = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
        g0 = m_lp; g1 = ~m_lp;
`else
        g0 = 1'b1; g1 = 1'b0;
`endif
      end else begin
        g0 = m0_req; g1 = m1_req;
      end
    end
    rv0 = 1'b0; rv1 = 1'b0; rd0 = 32'h0; rd1 = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].owner) begin rv1 = 1'b1; rd1 = rq[0].data; end
      else begin rv0 = 1'b1; rd0 = rq[0].data; end
    end
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_rd1 = m1_rdata; obs_csb = o_csb0; obs_wmask = o_wmask0;
    chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, g0});
    chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, g1});
    chk("m0_rvalid", {31'h0, m0_rvalid}, {31'h0, rv0});
    chk("m1_rvalid", {31'h0, m1_rvalid}, {31'h0, rv1});
    chk("m0_rdata", m0_rdata, rd0);
    chk("m1_rdata", m1_rdata, rd1);
    chk("csb", {31'h0, o_csb0}, {31'h0, e_csb});
    chk("web", {31'h0, o_web0}, {31'h0, e_web});
    chk("wmask", {28'h0, o_wmask0}, {28'h0, e_wmask});
    chk("waddr", {23'h0, o_waddr0}, {23'h0, e_addr});
    chk("din", o_din0, e_din);
    own = g1; we = g1 ? m1_we : m0_we; a = g1 ? m1_addr : m0_addr;
    mk = g1 ? m1_wmask : m0_wmask; wd = g1 ? m1_wdata : m0_wdata;
    @(posedge clk);
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (rst) begin
      model_reset();
    end else if (g0 || g1) begin
      m_lp = own;
      e_csb = 1'b0; e_web = ~we; e_wmask = mk; e_addr = a; e_din = wd;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (mk[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rq.push_back('{due: cyc + 2, owner: own, data: ref_mem[a]});
      end
    end else begin
      e_csb = 1'b1; e_web = 1'b1; e_wmask = 4'h0;
    end
    cyc++;
    #1;
  endtask

  function automatic logic [8:0] pick_addr();
    if ($urandom_range(0, 4) == 0) return 9'h1FF;
    else return 9'($urandom_range(0, 15));
  endfunction

  initial begin
    int n0, n1;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 9'h0; m0_wmask = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 9'h0; m1_wmask = 4'h0; m1_wdata = 32'h0;
    model_reset();

    // Reset state
    repeat (3) cycle();
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_csb", {31'h0, obs_csb}, 32'h1);
    end

    // Single read of 0x005
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h005;
    cycle();
    chk("single_gnt", {31'h0, obs_g0}, 32'h1);
    m0_req = 1'b0;
    cycle();
    chk("single_cmd_csb", {31'h0, obs_csb}, 32'h0);
    cycle();
    chk("single_rvalid", {31'h0, obs_rv0}, 32'h1);
    chk("single_rdata", obs_rd0, 32'hDEADBEEF);
    cycle();
    chk("single_rvalid_once", {31'h0, obs_rv0}, 32'h0);

    // Masked write then back-to-back read from m1
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h1FF; m1_wmask = 4'b0011; m1_wdata = 32'h11223344;
    cycle();
    m1_we = 1'b0;
    cycle();
    chk("mw_wmask", {28'h0, obs_wmask}, 32'h3);
    chk("mw_rd_gnt", {31'h0, obs_g1}, 32'h1);
    m1_req = 1'b0;
    cycle();
    chk("mw_no_bubble", {31'h0, obs_csb}, 32'h0);
    cycle();
    chk("mw_rdata", obs_rd1, 32'hAAAA3344);

    // Contention out of reset: both hold reads for 4 cycles
    rst = 1'b1; cycle(); rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h001;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h002;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
`ifdef SRAM_ARB_RR_EN
      chk("rr_gnt0", {31'h0, obs_g0}, (i % 2 == 0) ? 32'h1 : 32'h0);
`else
      chk("fp_gnt0", {31'h0, obs_g0}, 32'h1);
      chk("fp_gnt1", {31'h0, obs_g1}, 32'h0);
`endif
      if (obs_g0) m0_addr = m0_addr + 9'h2;
      if (obs_g1) m1_addr = m1_addr + 9'h2;
      n0 += obs_rv0; n1 += obs_rv1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) begin
      cycle();
      n0 += obs_rv0; n1 += obs_rv1;
    end
`ifdef SRAM_ARB_RR_EN
    chk("rr_rv0_count", n0, 32'd2);
    chk("rr_rv1_count", n1, 32'd2);
`else
    chk("fp_rv0_count", n0, 32'd4);
    chk("fp_rv1_count", n1, 32'd0);
`endif

    // Reset in the command cycle of a read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h007;
    cycle();
    m0_req = 1'b0; rst = 1'b1;
    cycle();
    chk("rst_mid_csb", {31'h0, obs_csb}, 32'h1);
    rst = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h005;
    cycle();
    chk("rst_mid_no_rv", {31'h0, obs_rv0}, 32'h0);
    chk("rst_release_gnt", {31'h0, obs_g1}, 32'h1);
    m1_req = 1'b0;
    cycle();
    cycle();
    chk("rst_resume_rdata", obs_rd1, 32'hDEADBEEF);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if (!m0_req && $urandom_range(0, 3) != 0) begin
        m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1)); m0_addr = pick_addr();
        m0_wmask = 4'($urandom); m0_wdata = $urandom;
      end
      if (!m1_req && $urandom_range(0, 3) != 0) begin
        m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1)); m1_addr = pick_addr();
        m1_wmask = 4'($urandom); m1_wdata = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      if (obs_g0) m0_req = 1'b0;
      if (obs_g1) m1_req = 1'b0;
    end
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: AW, default 9, SRAM word-address width.
REQ-002 Parameter: DW, default 32, data width; byte-mask width is DW/8.
REQ-003 Port: clk_i  in  1  sole clock, rising edge.
REQ-004 Port: rst_i  in  1  reset, asynchronous, active-high.
REQ-005 Ports: mN_req_i  in  1  access request, where N = 0 or 1.
REQ-006 Ports: mN_we_i  in  1  1 = write, 0 = read, where N = 0 or 1.
REQ-007 Ports: mN_addr_i  in  AW  word address, where N = 0 or 1.
REQ-008 Ports: mN_wmask_i  in  DW/8  byte write enables, where N = 0 or 1.
REQ-009 Ports: mN_wdata_i  in  DW  write data, where N = 0 or 1.
REQ-010 Ports: mN_gnt_o  out  1  request accepted this cycle, where N = 0 or 1.
REQ-011 Ports: mN_rvalid_o  out  1  read data valid, where N = 0 or 1.
REQ-012 Ports: mN_rdata_o  out  DW  read data, where N = 0 or 1.
REQ-013 Port: o_csb0  out  1  SRAM port-0 chip select, active-low.
REQ-014 Port: o_web0  out  1  SRAM port-0 write enable, active-low.
REQ-015 Port: o_wmask0  out  DW/8  SRAM byte mask.
REQ-016 Port: o_waddr0  out  AW  SRAM port-0 address.
REQ-017 Port: o_din0  out  DW  SRAM write data.
REQ-018 Port: i_dout0  in  DW  SRAM read data, valid in the cycle after the command cycle.

Function
REQ-019 Handshake: mN_gnt_o is combinational and asserted for at most one requester per cycle; an access is accepted at the rising edge where req and gnt are both 1.
REQ-020 Handshake: a requester holds req, we, addr, wmask and wdata stable until gnt; it may deassert req only after acceptance.
REQ-021 Throughput: one access is accepted per cycle when any request is pending; back-to-back accesses have no bubble.
REQ-022 SRAM command: the accepted access is registered onto o_csb0=0, o_web0=~we, o_waddr0, o_wmask0 and o_din0 for exactly the cycle after acceptance (command cycle).
REQ-023 Idle cycles: a cycle with no accepted access drives o_csb0=1, o_web0=1 and o_wmask0=0; o_waddr0 and o_din0 hold their previous values.
REQ-024 Read return: the cycle after the command cycle (acceptance+2) asserts mN_rvalid_o for one cycle to the originating requester, with mN_rdata_o=i_dout0.
REQ-025 Writes never assert rvalid.
REQ-026 Tracking: a 2-stage pipeline (valid, owner, is_read) tracks in-flight accesses; up to 2 reads are outstanding simultaneously.
REQ-027 Return order: rvalid returns in acceptance order.
REQ-028 Non-valid rdata: mN_rdata_o is 0 whenever mN_rvalid_o is 0.
REQ-029 Arbitration state: a 1-bit last-grant pointer lp is updated on every acceptance to the accepted requester.
REQ-030 Simultaneous requests: when both requesters request, the requester not equal to lp wins; a single requester always wins immediately.
REQ-031 Same address, same cycle: never arises (one access per cycle); a read accepted immediately after a write to the same address returns the new data.

Reset
REQ-032 While rst_i=1, all outputs shall be driven as follows: gnt=0, rvalid=0, rdata=0, o_csb0=1, o_web0=1, o_wmask0=0, o_waddr0=0, o_din0=0; lp=1, so m0 has priority first; the pipeline is cleared.
REQ-033 Reset mid-operation: in-flight reads are discarded and their rvalid is never asserted; the SRAM command of an aborted cycle is forced to deselect asynchronously.
REQ-034 Release: the first acceptance is possible in the first cycle after rst_i deasserts.

Configuration
REQ-035 Macro SRAM_ARB_RR_EN defined: round-robin arbitration per REQ-029 and REQ-030.
REQ-036 Macro SRAM_ARB_RR_EN undefined: fixed priority, m0 always beats m1; lp is not implemented; all other behaviour is identical.

Verification
REQ-037 Single read: m0 reads addr 0x005 while the SRAM model holds 0xDEADBEEF -> m0_gnt_o=1 at cycle T, o_csb0=0 and o_web0=1 at T+1, m0_rvalid_o=1 with rdata 0xDEADBEEF at T+2 only.
REQ-038 Masked write then read: m1 writes 0x11223344 to 0x1FF with mask 4'b0011 over a word holding 0xAAAAAAAA, then reads it back-to-back -> o_wmask0=4'b0011 in the command cycle, read returns 0xAAAA3344, and there is no idle cycle between the two commands.
REQ-039 Contention, RR build: both requesters hold reads for 4 cycles -> grants out of reset are m0, m1, m0, m1; each requester receives rvalid exactly twice, in order.
REQ-040 Contention, fixed-priority build: both requesters hold reads for 4 cycles -> m0 is granted all 4 cycles and m1_gnt_o stays 0.
REQ-041 Reset mid-read: rst_i pulses at T+1 after a read accepted at T -> no rvalid appears at T+2, o_csb0=1 during reset, and normal operation resumes afterwards.
REQ-042 Idle: no requests for 10 cycles -> o_csb0=1, both gnt=0 and both rvalid=0 throughout.
